sub_serial_32: RTL and testbench

Multi-cycle N-bit subtractor, the inverse-direction companion to the team's 32-bit adder datapath. Computes diff = a - b - borrow_in one CHUNK-bit slice per cycle, LSB slice first, with a ripple borrow held in a register between cycles. Sits behind valid/ready handshakes so an ALU or sequencer can trade area for latency.

---
 rtl/sub_serial_pkg.sv | 23 ++
 rtl/adder_n.sv | 20 ++
 rtl/sub_serial_32.sv | 174 +++++++++++++++++
 tb/tb_sub_serial_32.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sub_serial_pkg                                                   |
// | FSM state encoding and counter sizing for sub_serial_32.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width; never below one bit, even for a single slice.
  function automatic int cnt_width(input int n, input int chunk);
    int slices;
    slices = n / chunk;
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_n                                                          |
// | Combinational N-bit ripple adder with carry in and carry out.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule
`default_nettype wire

// File: rtl/sub_serial_32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sub_serial_32                                                    |
// | Multi-cycle subtractor: diff = a - b - borrow_in, CHUNK bits per |
// | cycle, LSB first. Define SUB_SERIAL_FLAGS_EN for zero/negative/  |
// | overflow status outputs.                                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sub_serial_32
  import sub_serial_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SUB_SERIAL_FLAGS_EN
  ,
  output logic         zero,
  output logic         negative,
  output logic         overflow
`endif
);

  localparam int NS = N / CHUNK;
  localparam int CW = cnt_width(N, CHUNK);

  generate
    if ((CHUNK < 1) || (N % CHUNK != 0)) begin : g_width_check
      $error("sub_serial_32: N must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_diff;
  logic [CW-1:0]   r_cnt;
  logic            r_borrow;
  logic            r_borrow_out;

  logic [CHUNK-1:0] w_a_sl [NS];
  logic [CHUNK-1:0] w_b_sl [NS];
  logic [CHUNK-1:0] w_a_cur;
  logic [CHUNK-1:0] w_b_cur;
  logic [CHUNK-1:0] w_d;
  logic             w_carry;
  logic             w_bw;
  logic             w_last;
  logic [N-1:0]     w_diff_next;

  // Slice views of the operands, and the result with slice r_cnt replaced.
  for (genvar i = 0; i < NS; i++) begin : g_slices
    assign w_a_sl[i] = r_a[i*CHUNK +: CHUNK];
    assign w_b_sl[i] = r_b[i*CHUNK +: CHUNK];
    assign w_diff_next[i*CHUNK +: CHUNK] =
        (r_cnt == CW'(i)) ? w_d : r_diff[i*CHUNK +: CHUNK];
  end

  assign w_a_cur = w_a_sl[r_cnt];
  assign w_b_cur = w_b_sl[r_cnt];
  assign w_last  = (r_cnt == CW'(NS - 1));

  // a - b - br == a + ~b + ~br; the adder's carry out is the inverted borrow.
  adder_n #(
    .N (CHUNK)
  ) u_slice (
    .a     (w_a_cur),
    .b     (~w_b_cur),
    .c_in  (~r_borrow),
    .sum   (w_d),
    .c_out (w_carry)
  );

  assign w_bw = ~w_carry;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    i_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (o_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= borrow_in;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_diff   <= w_diff_next;
          r_borrow <= w_bw;
          if (w_last) begin
            r_borrow_out <= w_bw;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

`ifdef SUB_SERIAL_FLAGS_EN
  logic r_zero;
  logic r_negative;
  logic r_overflow;

  // Flags come from the fully assembled result at the final slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if ((r_state == BUSY) && w_last) begin
      r_zero     <= (w_diff_next == '0);
      r_negative <= w_diff_next[N-1];
      r_overflow <= (r_a[N-1] != r_b[N-1]) && (w_diff_next[N-1] != r_a[N-1]);
    end
  end

  assign zero     = r_zero;
  assign negative = r_negative;
  assign overflow = r_overflow;
`else
  // Status flags not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_serial_32.sv
`default_nettype none
// Scoreboard bench for sub_serial_32: random and directed subtractions
// against an arithmetic reference model.
module tb_sub_serial_32;

  localparam int N  = 32;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          borrow_in;
  logic          o_valid;
  logic          o_ready;
  logic [N-1:0]  diff;
  logic          borrow_out;
`ifdef SUB_SERIAL_FLAGS_EN
  logic          zero;
  logic          negative;
  logic          overflow;
`endif

  sub_serial_32 #(.N(N), .CHUNK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_SERIAL_FLAGS_EN
    ,
    .zero       (zero),
    .negative   (negative),
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         bo;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  bit   rand_ready = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain 33-bit unsigned arithmetic.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
    exp_t e;
    logic [N:0] full;
    full = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
    e.d  = full[N-1:0];
    e.bo = full[N];
    e.z  = (e.d == '0);
    e.n  = e.d[N-1];
    e.v  = (x[N-1] != y[N-1]) && (e.d[N-1] != x[N-1]);
    return e;
  endfunction

  // Monitor: compares at each output handshake, checks latency and holding.
  bit           prev_valid = 0;
  bit           expect_idle = 0;
  logic [N-1:0] prev_diff;
  logic         prev_bo;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 0;
      expect_idle = 0;
    end else begin
      if (o_valid) begin
        if (!prev_valid) chk("latency", 64'(cyc - last_acc), 64'(NS));
        else begin
          chk("hold_diff", 64'(diff), 64'(prev_diff));
          chk("hold_borrow", 64'(borrow_out), 64'(prev_bo));
        end
        chk("i_ready_in_done", 64'(i_ready), 64'd0);
        if (o_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("diff", 64'(diff), 64'(e.d));
            chk("borrow_out", 64'(borrow_out), 64'(e.bo));
`ifdef SUB_SERIAL_FLAGS_EN
            chk("zero", 64'(zero), 64'(e.z));
            chk("negative", 64'(negative), 64'(e.n));
            chk("overflow", 64'(overflow), 64'(e.v));
`endif
          end
          expect_idle = 1;
        end
      end else if (expect_idle) begin
        chk("back_to_idle", 64'(i_ready), 64'd1);
        expect_idle = 0;
      end
      prev_valid = o_valid;
      prev_diff  = diff;
      prev_bo    = borrow_out;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) o_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi, input bit push);
    for (int i = 0; i < 400 && !i_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!i_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      return;
    end
    a = x; b = y; borrow_in = bi; i_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) sb.push_back(model(x, y, bi));
    i_valid = 1'b0;
  endtask

  // Operands churn while busy; the result must reflect the latched values only.
  task automatic scramble(input int n);
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom; borrow_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [N-1:0] va [8] = '{32'd5, 32'd0, 32'd10, 32'h80000000, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [N-1:0] vb [8] = '{32'd3, 32'd1, 32'd10, 32'd1, 32'h1234, 32'd0, 32'd0, 32'hFFFFFFFF};
    logic         vi [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; i_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_borrow", 64'(borrow_out), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vi[i], 1'b1);
      scramble(NS);
      drain();
    end

    // Backpressure: stall five cycles in DONE with stray i_valid pulses.
    o_ready = 1'b0;
    do_op($urandom, $urandom, 1'b1, 1'b1);
    for (int i = 0; i < 40 && !o_valid; i++) begin
      @(posedge clk);
      #1;
    end
    if (!o_valid) chk("valid_timeout", 64'd1, 64'd0);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; i_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    drain();

    // Reset in the fourth BUSY cycle discards the operation.
    @(posedge clk);
    #1;
    do_op(32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0);
    scramble(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_i_ready", 64'(i_ready), 64'd1);
    chk("midrst_o_valid", 64'(o_valid), 64'd0);
    chk("midrst_diff", 64'(diff), 64'd0);
    rst = 1'b0;
    do_op(32'd100, 32'd1, 1'b0, 1'b1);
    scramble(NS);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      scramble(NS);
    end
    drain();
    rand_ready = 0;
    o_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
